// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage sitting between the PC, an asynchronous-read
// instruction memory and the decode stage.
//
// The PC drives imem_addr directly. Each fetched word is written, together
// with the PC that fetched it, into a small FIFO (the fetch queue). Decode
// takes the queue head over a valid/ready handshake. A branch redirect from
// execute flushes the queue and reloads the PC.
//
// Parameters:
//   RESET_VECTOR  PC loaded on reset (word aligned)
//   DEPTH         fetch queue entries (power of two, 2..8)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous active-low reset
//   imem_addr        byte address to instruction memory (equals pc)
//   imem_rd          instruction word returned combinationally for imem_addr
//   fetch_en         1 = fetch allowed, 0 = pause (queue still drains)
//   redirect_valid   branch / PC write taken this cycle
//   redirect_target  new fetch address, low two bits forced to zero
//   instr_valid      queue head valid
//   instr_ready      decode accepts the head this cycle
//   instr            head instruction word
//   instr_pc         address of the head instruction
//   instr_pc8        instr_pc + 8 (ARM PC-read value)
//   halted           fetch stopped on a branch-to-self
//
// Build option:
//   FETCH_HALT_DETECT_EN  when defined, fetching a "B ." (32'hEAFFFFFE) word
//                         enqueues it and then stops fetching until the next
//                         redirect. When undefined, halted is tied to 0 and
//                         the self-loop is fetched like any other word.
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    output logic        halted
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSE  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

`ifdef FETCH_HALT_DETECT_EN
    localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFE;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]      pc;
    logic [1:0]       state;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      q_instr [DEPTH];
    logic [31:0]      q_pc    [DEPTH];

    // Registered copy of the queue head. Kept separate from the storage
    // array so the outputs reset to zero and hold their last value while
    // the queue is empty.
    logic             head_valid;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;

    // -------------------------------------------------------------------------
    // Next-state signals
    // -------------------------------------------------------------------------
    logic             deq;
    logic             enq;
    logic             full;
    logic             halt_hit;
    logic [31:0]      target_aligned;
    logic [31:0]      pc_nxt;
    logic [1:0]       state_nxt;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             head_load;
    logic [31:0]      head_instr_nxt;
    logic [31:0]      head_pc_nxt;

    assign imem_addr = pc;

    assign deq  = head_valid & instr_ready;
    assign full = (count == CNT_FULL);
    // A full queue still accepts a new word when the head leaves in the
    // same cycle, so a streaming decode sees no bubbles.
    assign enq  = (state == ST_RUN) & fetch_en & ~redirect_valid & (~full | deq);

    assign target_aligned = redirect_target & ~32'h0000_0003;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = enq & (imem_rd == HALT_WORD);
    assign halted   = (state == ST_HALTED);
`else
    assign halt_hit = 1'b0;
    assign halted   = 1'b0;
`endif

    // PC: redirect wins, otherwise advance on every enqueue. 32-bit add
    // wraps FFFF_FFFC to 0 naturally.
    always_comb begin
        // NOTE: every signal written in an always_comb gets a default value
        // first so no path through the block can infer a latch.
        pc_nxt = pc;
        if (redirect_valid) begin
            pc_nxt = target_aligned;
        end else if (enq) begin
            pc_nxt = pc + 32'd4;
        end
    end

    // FSM. A redirect leaves RUN/PAUSE unchanged and is the only way out
    // of HALTED.
    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            if (state == ST_HALTED) begin
                state_nxt = ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_hit) begin
                        state_nxt = ST_HALTED;
                    end else if (!fetch_en) begin
                        state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (fetch_en) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_HALTED: state_nxt = ST_HALTED;
                default:   state_nxt = ST_RUN;
            endcase
        end
    end

    // Queue pointers and occupancy. A redirect empties the queue and voids
    // any head transfer in the same cycle.
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (redirect_valid) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (deq) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    // Next head contents. If the slot that becomes the head is the one
    // being written this cycle, take the incoming word directly; that only
    // happens when the write makes the queue hold exactly one entry.
    always_comb begin
        head_load      = (count_nxt != '0);
        head_instr_nxt = q_instr[rd_ptr_nxt];
        head_pc_nxt    = q_pc[rd_ptr_nxt];
        if (enq && (wr_ptr == rd_ptr_nxt)) begin
            head_instr_nxt = imem_rd;
            head_pc_nxt    = pc;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            pc         <= RESET_VECTOR;
            state      <= ST_RUN;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_instr <= '0;
            head_pc    <= '0;
        end else begin
            pc         <= pc_nxt;
            state      <= state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr     <= wr_ptr_nxt;
            count      <= count_nxt;
            head_valid <= head_load;
            if (head_load) begin
                head_instr <= head_instr_nxt;
                head_pc    <= head_pc_nxt;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // ever read after it has been written, and reset clears the count that
    // qualifies it. A write during reset is harmless for the same reason.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_instr[wr_ptr] <= imem_rd;
            q_pc[wr_ptr]    <= pc;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign instr_valid = head_valid;
    assign instr       = head_instr;
    assign instr_pc    = head_pc;
    assign instr_pc8   = head_pc + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed bench for fetch_stage. Two instances share control inputs:
//   dut   RESET_VECTOR = 0,          imem returns word == address
//                                    (except 0xE4 returns 32'hEAFFFFFE)
//   dutw  RESET_VECTOR = FFFF_FFF8,  imem returns word == address
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_ready;

    logic [31:0] imem_addr,  imem_rd;
    logic        instr_valid, halted;
    logic [31:0] instr, instr_pc, instr_pc8;

    logic [31:0] imem_addr_w, imem_rd_w;
    logic        instr_valid_w, halted_w;
    logic [31:0] instr_w, instr_pc_w, instr_pc8_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_rd   = (imem_addr == 32'h0000_00E4) ? 32'hEAFF_FFFE : imem_addr;
    assign imem_rd_w = imem_addr_w;

    fetch_stage #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rd         (imem_rd),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_pc8       (instr_pc8),
        .halted          (halted)
    );

    fetch_stage #(.RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(2)) dutw (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr_w),
        .imem_rd         (imem_rd_w),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid_w),
        .instr_ready     (instr_ready),
        .instr           (instr_w),
        .instr_pc        (instr_pc_w),
        .instr_pc8       (instr_pc8_w),
        .halted          (halted_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b0;
        fetch_en        = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        instr_ready     = 1'b1;

        // ---- reset state ----
        step();
        step();
        check("rst_valid",    32'(instr_valid), 32'h0);
        check("rst_instr",    instr,            32'h0);
        check("rst_instr_pc", instr_pc,         32'h0);
        check("rst_halted",   32'(halted),      32'h0);
        check("rst_addr",     imem_addr,        32'h0);
        check("rst_addr_w",   imem_addr_w,      32'hFFFF_FFF8);

        // ---- sequential fetch, ready=1; wrap on second instance ----
        reset = 1'b1;
        step();
        check("seq0_valid", 32'(instr_valid), 32'h1);
        check("seq0_pc",    instr_pc,         32'h0);
        check("seq0_instr", instr,            32'h0);
        check("seq0_pc8",   instr_pc8,        32'h8);
        check("seq0_addr",  imem_addr,        32'h4);
        check("wrap0_pc",   instr_pc_w,       32'hFFFF_FFF8);
        step();
        check("seq1_pc",    instr_pc,         32'h4);
        check("seq1_instr", instr,            32'h4);
        check("seq1_pc8",   instr_pc8,        32'hC);
        check("wrap1_pc",   instr_pc_w,       32'hFFFF_FFFC);
        check("wrap1_pc8",  instr_pc8_w,      32'h0000_0004);
        step();
        check("seq2_pc",    instr_pc,         32'h8);
        check("seq2_pc8",   instr_pc8,        32'h10);
        check("wrap2_pc",   instr_pc_w,       32'h0000_0000);
        check("wrap2_instr",instr_w,          32'h0000_0000);
        step();
        check("seq3_pc",    instr_pc,         32'hC);
        check("seq3_instr", instr,            32'hC);
        check("seq3_pc8",   instr_pc8,        32'h14);

        // ---- reset mid-operation discards the queue ----
        reset = 1'b0;
        step();
        check("rst2_valid", 32'(instr_valid), 32'h0);
        check("rst2_pc",    instr_pc,         32'h0);
        check("rst2_addr",  imem_addr,        32'h0);

        // ---- backpressure: ready=0 for 5 cycles ----
        reset       = 1'b1;
        instr_ready = 1'b0;
        step();
        check("bp0_pc",   instr_pc,  32'h0);
        check("bp0_addr", imem_addr, 32'h4);
        step();
        check("bp1_addr", imem_addr, 32'h8);
        step();
        check("bp2_addr", imem_addr, 32'h8);
        step();
        step();
        check("bp4_valid", 32'(instr_valid), 32'h1);
        check("bp4_pc",    instr_pc,         32'h0);
        check("bp4_addr",  imem_addr,        32'h8);
        instr_ready = 1'b1;
        step();
        check("bp5_pc",    instr_pc,  32'h4);
        check("bp5_addr",  imem_addr, 32'hC);

        // ---- redirect while head pc=4 (queue holds 4,8) ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        step();
        check("rd_valid", 32'(instr_valid), 32'h0);
        check("rd_addr",  imem_addr,        32'h40);
        redirect_valid  = 1'b0;
        step();
        check("rd1_valid", 32'(instr_valid), 32'h1);
        check("rd1_pc",    instr_pc,         32'h40);
        check("rd1_instr", instr,            32'h40);
        step();
        check("rd2_pc",    instr_pc,         32'h44);

        // ---- pause: fetch_en=0 for 3 cycles ----
        fetch_en = 1'b0;
        step();
        check("pz0_valid", 32'(instr_valid), 32'h0);
        check("pz0_addr",  imem_addr,        32'h48);
        step();
        step();
        check("pz2_valid", 32'(instr_valid), 32'h0);
        check("pz2_addr",  imem_addr,        32'h48);
        check("pz2_hold",  instr_pc,         32'h44);
        fetch_en = 1'b1;
        step();
        check("pz3_valid", 32'(instr_valid), 32'h0);
        check("pz3_addr",  imem_addr,        32'h48);
        step();
        check("pz4_valid", 32'(instr_valid), 32'h1);
        check("pz4_pc",    instr_pc,         32'h48);
        step();
        check("pz5_pc",    instr_pc,         32'h4C);

        // ---- branch-to-self at 0xE4 ----
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_00E4;
        step();
        check("h0_valid", 32'(instr_valid), 32'h0);
        check("h0_addr",  imem_addr,        32'hE4);
        redirect_valid  = 1'b0;
        step();
        check("h1_pc",     instr_pc,    32'hE4);
        check("h1_instr",  instr,       32'hEAFF_FFFE);
        check("h1_halted", 32'(halted), 32'(HALT_EN));
        check("h1_addr",   imem_addr,   32'hE8);
        step();
        check("h2_valid",  32'(instr_valid), HALT_EN ? 32'h0 : 32'h1);
        check("h2_addr",   imem_addr,        HALT_EN ? 32'hE8 : 32'hEC);
        check("h2_halted", 32'(halted),      32'(HALT_EN));
        step();
        check("h3_valid",  32'(instr_valid), HALT_EN ? 32'h0 : 32'h1);
        check("h3_addr",   imem_addr,        HALT_EN ? 32'hE8 : 32'hF0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0;
        step();
        check("h4_halted", 32'(halted),      32'h0);
        check("h4_addr",   imem_addr,        32'h0);
        check("h4_valid",  32'(instr_valid), 32'h0);
        redirect_valid  = 1'b0;
        step();
        check("h5_valid",  32'(instr_valid), 32'h1);
        check("h5_pc",     instr_pc,         32'h0);
        check("h5_halted", 32'(halted_w),    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
